// File: rtl/grid_line_clear_pkg.sv
// Shared playfield constants for the grid clear engine, renderer and game controller.
package grid_line_clear_pkg;

    localparam int GRID_COLS   = 10;
    localparam int GRID_ROWS   = 20;
    localparam int CELL_W      = 8;
    localparam int GRID_ADDR_W = 8;
    localparam int LINES_W     = 5;

    localparam logic [CELL_W-1:0] CELL_EMPTY = '0;

endpackage

// File: rtl/grid_line_clear_row_buffer.sv
// One grid row held in registers: indexed write, indexed read, and a row_full flag.
module grid_line_clear_row_buffer #(
    parameter int COLS       = 10,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_W      = 4
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [IDX_W-1:0]      rd_idx_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  row_full_o
);

    logic [COLS-1:0][DATA_WIDTH-1:0] cell_q;
    logic [COLS-1:0]                 occ;

    for (genvar g = 0; g < COLS; g++) begin : g_cell
        always_ff @(posedge clk) begin
            if (wr_en_i && (wr_idx_i == IDX_W'(g))) begin
                cell_q[g] <= wr_data_i;
            end
        end
        assign occ[g] = |cell_q[g];
    end

    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < COLS; i++) begin
            if (rd_idx_i == IDX_W'(i)) rd_data_o = cell_q[i];
        end
    end

    assign row_full_o = &occ;

endmodule

// File: rtl/grid_line_clear.sv
// Bottom-up full-row removal pass over the playfield memory (port A master).
// Rows are compacted in place: src walks every row, dst only advances past kept rows.
module grid_line_clear
    import grid_line_clear_pkg::*;
#(
    parameter int COLS       = GRID_COLS,
    parameter int ROWS       = GRID_ROWS,
    parameter int DATA_WIDTH = CELL_W,
    parameter int ADDR_WIDTH = GRID_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [LINES_W-1:0]    lines_cleared,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int COL_W = $clog2(COLS + 1);
    localparam int ROW_W = $clog2(ROWS);

    localparam logic [COL_W-1:0]        COL_END   = COL_W'(COLS);
    localparam logic [COL_W-1:0]        COL_LAST  = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0]        COL_ONE   = COL_W'(1);
    localparam logic signed [ROW_W:0]   ROW_LAST  = (ROW_W + 1)'(ROWS - 1);
    localparam logic signed [ROW_W:0]   ROW_ONE   = (ROW_W + 1)'(1);
    localparam logic signed [ROW_W:0]   ROW_ZERO  = '0;
    localparam logic [ADDR_WIDTH-1:0]   BASE_LAST = ADDR_WIDTH'((ROWS - 1) * COLS);
    localparam logic [ADDR_WIDTH-1:0]   BASE_STEP = ADDR_WIDTH'(COLS);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_CHECK, S_WRITE, S_ZERO, S_DONE} state_e;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } mem_req_t;

    state_e                  state_q, state_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic signed [ROW_W:0]   src_row_q, src_row_d, dst_row_q, dst_row_d;
    logic [ADDR_WIDTH-1:0]   src_base_q, src_base_d, dst_base_q, dst_base_d;
    logic [LINES_W-1:0]      cnt_q, cnt_d, lines_q, lines_d;
    logic                    rd_vld_q;

    mem_req_t                req;
    logic                    rd_issue, step_src, step_dst;
    logic                    buf_we, row_full;
    logic [DATA_WIDTH-1:0]   buf_rd;

    grid_line_clear_row_buffer #(
        .COLS       (COLS),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (COL_W)
    ) u_row_buf (
        .clk        (clk),
        .wr_en_i    (buf_we),
        .wr_idx_i   (col_q - COL_ONE),
        .wr_data_i  (mem_rdata),
        .rd_idx_i   (col_q),
        .rd_data_o  (buf_rd),
        .row_full_o (row_full)
    );

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        src_row_d  = src_row_q;
        dst_row_d  = dst_row_q;
        src_base_d = src_base_q;
        dst_base_d = dst_base_q;
        cnt_d      = cnt_q;
        lines_d    = lines_q;
        req        = '0;
        rd_issue   = 1'b0;
        step_src   = 1'b0;
        step_dst   = 1'b0;
        // Read data for the address issued last cycle lands in slot col-1.
        buf_we     = rd_vld_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_READ;
                    col_d      = '0;
                    src_row_d  = ROW_LAST;
                    dst_row_d  = ROW_LAST;
                    src_base_d = BASE_LAST;
                    dst_base_d = BASE_LAST;
                    cnt_d      = '0;
                end
            end
            S_READ: begin
                if (col_q != COL_END) begin
                    rd_issue = 1'b1;
                    req.addr = src_base_q + ADDR_WIDTH'(col_q);
                    col_d    = col_q + COL_ONE;
                end else begin
                    state_d = S_CHECK;
                    col_d   = '0;
                end
            end
            S_CHECK: begin
                if (row_full) begin
                    cnt_d    = cnt_q + LINES_W'(1);
                    step_src = 1'b1;
                end else if (src_row_q == dst_row_q) begin
                    step_src = 1'b1;
                    step_dst = 1'b1;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                req.we    = 1'b1;
                req.addr  = dst_base_q + ADDR_WIDTH'(col_q);
                req.wdata = buf_rd;
                if (col_q == COL_LAST) begin
                    col_d    = '0;
                    step_src = 1'b1;
                    step_dst = 1'b1;
                end else begin
                    col_d = col_q + COL_ONE;
                end
            end
            S_ZERO: begin
                req.we    = 1'b1;
                req.addr  = dst_base_q + ADDR_WIDTH'(col_q);
                req.wdata = DATA_WIDTH'(CELL_EMPTY);
                if (col_q == COL_LAST) begin
                    col_d      = '0;
                    dst_row_d  = dst_row_q - ROW_ONE;
                    dst_base_d = dst_base_q - BASE_STEP;
                    if (dst_row_q == ROW_ZERO) state_d = S_DONE;
                end else begin
                    col_d = col_q + COL_ONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (step_src) begin
            src_row_d  = src_row_q - ROW_ONE;
            src_base_d = src_base_q - BASE_STEP;
        end
        if (step_dst) begin
            dst_row_d  = dst_row_q - ROW_ONE;
            dst_base_d = dst_base_q - BASE_STEP;
        end
        // Sign bit set means the row pointer has moved above row 0.
        if (step_src || step_dst) begin
            if (src_row_d[ROW_W]) state_d = dst_row_d[ROW_W] ? S_DONE : S_ZERO;
            else                  state_d = S_READ;
        end

        if ((state_d == S_DONE) && (state_q != S_DONE)) lines_d = cnt_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            src_row_q  <= '0;
            dst_row_q  <= '0;
            src_base_q <= '0;
            dst_base_q <= '0;
            cnt_q      <= '0;
            lines_q    <= '0;
            rd_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            src_row_q  <= src_row_d;
            dst_row_q  <= dst_row_d;
            src_base_q <= src_base_d;
            dst_base_q <= dst_base_d;
            cnt_q      <= cnt_d;
            lines_q    <= lines_d;
            rd_vld_q   <= rd_issue;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign lines_cleared = lines_q;
    assign mem_we        = req.we;
    assign mem_addr      = req.addr;
    assign mem_wdata     = req.wdata;

endmodule

// File: tb/tb_grid_line_clear.sv
// Bench for grid_line_clear: grid memory model, directed table, random grids, reset/start corners.
module tb_grid_line_clear;

    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int TMO  = 2000;

    logic       clk = 1'b0;
    logic       reset, start;
    logic       busy, done, mem_we;
    logic [4:0] lines_cleared;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    logic [7:0] mem     [0:255];
    logic [7:0] exp_mem [0:255];
    int         exp_lines, exp_moved;
    int         n_checks = 0, n_errors = 0;

    typedef struct {
        int         kind;
        int         exp_lines;
        int         exp_writes;
        int         exp_cycles;
        int         chk_addr;
        logic [7:0] chk_val;
    } vec_t;

    grid_line_clear dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic setup(input int kind);
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        case (kind)
            1: begin
                for (int c = 0; c < COLS; c++) mem[190 + c] = 8'h03;
                mem[180] = 8'h05;
            end
            2: begin
                for (int r = 16; r < 20; r++)
                    for (int c = 0; c < COLS; c++) mem[r*COLS + c] = 8'(r - 10);
                mem[154] = 8'h07;
            end
            3: begin
                for (int c = 0; c < COLS; c++) begin
                    mem[190 + c] = 8'h03;
                    mem[170 + c] = 8'h04;
                    mem[180 + c] = (c % 2 == 0) ? 8'(c + 1) : 8'h00;
                    mem[160 + c] = (c % 3 == 1) ? 8'(8'h20 + c) : 8'h00;
                end
            end
            4: for (int a = 0; a < ROWS*COLS; a++) mem[a] = 8'h09;
            default: ;
        endcase
    endtask

    task automatic setup_random();
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        for (int r = 0; r < ROWS; r++) begin
            int mode = $urandom_range(0, 9);
            for (int c = 0; c < COLS; c++) begin
                if (mode < 4)      mem[r*COLS + c] = 8'($urandom_range(1, 255));
                else if (mode < 8) mem[r*COLS + c] = $urandom_range(0, 1) ? 8'($urandom_range(1, 255)) : 8'h00;
            end
            if (mode >= 4 && mode < 8) mem[r*COLS + $urandom_range(0, COLS-1)] = 8'h00;
        end
    endtask

    // Compaction model: keep the non-full rows in bottom-up order and stack them at the bottom.
    task automatic build_model();
        int kept[$];
        bit full;
        exp_lines = 0;
        exp_moved = 0;
        for (int a = 0; a < 256; a++) exp_mem[a] = mem[a];
        for (int r = ROWS - 1; r >= 0; r--) begin
            full = 1'b1;
            for (int c = 0; c < COLS; c++) if (mem[r*COLS + c] == 8'h00) full = 1'b0;
            if (full) exp_lines++;
            else begin
                if (exp_lines > 0) exp_moved++;
                kept.push_back(r);
            end
        end
        for (int i = 0; i < ROWS; i++)
            for (int c = 0; c < COLS; c++)
                exp_mem[(ROWS-1-i)*COLS + c] = (i < kept.size()) ? mem[kept[i]*COLS + c] : 8'h00;
    endtask

    function automatic int grid_diffs();
        int bad = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== exp_mem[a]) bad++;
        return bad;
    endfunction

    task automatic run_pass(input int poke, input bit at_done,
                            output int cyc, output int nwr, output int ndone);
        int nbusy = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        cyc = 2; nwr = 0; ndone = 0;
        chk("busy_rise", int'(busy), 1);
        while (!done && cyc < TMO) begin
            start = (cyc == poke);
            nwr += int'(mem_we);
            @(posedge clk); #1; cyc++;
        end
        start = 1'b0;
        chk("done_seen", int'(done), 1);
        if (at_done) start = 1'b1;
        for (int i = 0; i < 15; i++) begin
            ndone += int'(done);
            @(posedge clk); #1;
            start = 1'b0;
            nbusy += int'(busy);
        end
        chk("idle_after_done", nbusy, 0);
    endtask

    initial begin
        vec_t vecs[5];
        int cyc, nwr, ndone, guard;

        vecs[0] = '{0,  0,   0, 242, 190, 8'h00};
        vecs[1] = '{1,  1, 200, 442, 190, 8'h05};
        vecs[2] = '{2,  4, 200, 442, 194, 8'h07};
        vecs[3] = '{3,  2, 200, 442, 181, 8'h21};
        vecs[4] = '{4, 20, 200, 442, 199, 8'h00};

        reset = 1'b1; start = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_we", int'(mem_we), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_wdata", int'(mem_wdata), 0);
        chk("rst_lines", int'(lines_cleared), 0);
        @(negedge clk); reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            setup(vecs[v].kind);
            build_model();
            chk("model_lines", exp_lines, vecs[v].exp_lines);
            run_pass(0, 1'b0, cyc, nwr, ndone);
            chk("cycles", cyc, vecs[v].exp_cycles);
            chk("writes", nwr, vecs[v].exp_writes);
            chk("done_pulses", ndone, 1);
            chk("lines", int'(lines_cleared), vecs[v].exp_lines);
            chk("cell", int'(mem[vecs[v].chk_addr]), int'(vecs[v].chk_val));
            chk("grid", grid_diffs(), 0);
        end

        for (int t = 0; t < 6; t++) begin
            setup_random();
            build_model();
            run_pass(0, 1'b0, cyc, nwr, ndone);
            chk("rnd_lines", int'(lines_cleared), exp_lines);
            chk("rnd_cycles", cyc, 2 + ROWS*(COLS+2) + COLS*(exp_moved + exp_lines));
            chk("rnd_grid", grid_diffs(), 0);
        end

        // start while busy and start during the done cycle are both dropped
        setup(3);
        build_model();
        run_pass(50, 1'b1, cyc, nwr, ndone);
        chk("busy_start_dones", ndone, 1);
        chk("busy_start_cycles", cyc, 442);
        chk("busy_start_grid", grid_diffs(), 0);

        // reset in the middle of a write burst
        setup(1);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        guard = 0;
        while (!mem_we && guard < TMO) begin
            @(posedge clk); #1; guard++;
        end
        chk("reached_write", int'(mem_we), 1);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_we", int'(mem_we), 0);
        chk("midrst_addr", int'(mem_addr), 0);
        chk("midrst_wdata", int'(mem_wdata), 0);
        chk("midrst_lines", int'(lines_cleared), 0);
        @(negedge clk); reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_idle", int'(busy), 0);
        build_model();
        run_pass(0, 1'b0, cyc, nwr, ndone);
        chk("rerun_lines", int'(lines_cleared), exp_lines);
        chk("rerun_grid", grid_diffs(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/grid_line_clear.md
Name: grid_line_clear

Overview:
Port-A master for the playfield grid memory: on request it scans the Tetris grid bottom-up and removes every completely filled row. Rows above each removed row shift down, and the vacated top rows are cleared to empty. It sits between the game controller, which pulses start after a piece locks, and the grid memory's read/write port. The renderer keeps the read-only port.

Parameters:
COLS, 10, cells per row
ROWS, 20, rows in grid; ROWS*COLS must be at most 2**ADDR_WIDTH
DATA_WIDTH, 8, cell width; value 0 = empty, any nonzero value = occupied (colour code)
ADDR_WIDTH, 8, grid memory address width

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high
start  in  1  single-cycle request to run a clear pass
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the pass completes
lines_cleared  out  5  number of full rows removed in the last pass; holds until the next start
mem_addr  out  ADDR_WIDTH  grid address, linear: row*COLS + col, row 0 = top
mem_wdata  out  DATA_WIDTH  write data
mem_we  out  1  write enable
mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after mem_addr is presented

Behaviour:
- Reset values: busy=0, done=0, lines_cleared=0, mem_we=0, mem_addr=0, mem_wdata=0; FSM in IDLE.
- Address math: no multiplier. Keep two row-base registers, src_base and dst_base. Both start at (ROWS-1)*COLS (190 at defaults). Decrement a base by COLS when its row is consumed. mem_addr = base + col.
- IDLE: when start=1, set src_row=dst_row=ROWS-1, set cleared count=0 and go to READ. busy rises on the next cycle.
- READ: present src_base+col for col=0..COLS-1 on consecutive cycles. Capture mem_rdata into row buffer slot col-1 one cycle later. Total COLS+1 cycles, then go to CHECK.
- CHECK, 1 cycle:
  - If all buffer slots are nonzero: increment the count and decrement src. Do not write.
  - Else if src==dst: no write is needed. Decrement src and dst.
  - Else: go to WRITE.
  - After the decision, if src has passed row 0, go to ZERO when dst_row >= 0; otherwise go to DONE. Otherwise return to READ.
- WRITE: COLS cycles. mem_we=1, mem_addr=dst_base+col, mem_wdata=buffer[col]. Then decrement src and dst and apply the same exit test as CHECK.
- ZERO: for each row from dst_row down to 0, write 0 to every col (mem_we=1). Then go to DONE.
- DONE, 1 cycle: done=1, update lines_cleared, busy=0 on the next cycle, return to IDLE.
- mem_we is 0 in every state except WRITE and ZERO.
- start while busy: ignored. It is not queued.
- start in the same cycle as DONE: ignored; the pass must be re-requested.
- reset mid-pass: return immediately to IDLE with reset values. Memory contents already written are not restored. The controller must re-run the pass.
- Row-count signals are wide enough to hold -1, the "passed row 0" sentinel. Use signed or ROW_W+1 bits.
- Worst case, all ROWS full: ROWS*(COLS+2) + ROWS*COLS + 2 cycles.

Decomposition:
- Shared include grid_defs.vh: GRID_COLS, GRID_ROWS, CELL_EMPTY (0), address-width constant. The renderer and game controller use the same file.
- FSM state encodings stay local to the module.
- One natural sub-module: grid_row_buffer. It holds COLS registers with indexed write and indexed read, plus a combinational row_full output (AND-reduction of nonzero tests).

Test Plan:
- Empty grid, start -> no mem_we asserted in the whole pass; done after 20*(10+2)+2 cycles; lines_cleared=0.
- Row 19 full (all cells 8'h3) and row 18 = {8'h5,0,...,0}, start -> row 19 = {8'h5,0,...}, rows 0-18 all 0; lines_cleared=1.
- Rows 16-19 full, row 15 has one cell 8'h7 at col 4 -> cell 8'h7 at address 19*10+4=194; rows 0-18 zero; lines_cleared=4.
- Rows 19 and 17 full, row 18 = pattern A, row 16 = pattern B -> row 19 = A, row 18 = B, rows 0-17 zero; lines_cleared=2.
- All 20 rows full -> all 200 cells 0; lines_cleared=20; exactly 200 write cycles observed.
- Assert reset during WRITE; also pulse start while busy -> outputs at reset values the next cycle, FSM in IDLE; a start pulsed during a pass does not start a second pass (exactly one done pulse).
